mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default timing for the IF/MEM port arbiter on the unified RAM.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_MEM = 2'd2} arb_state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_MEM = 1'b1} arb_owner_t;

    localparam int DEF_MEM_LATENCY  = 2;
    localparam int DEF_MEM_PRIO_MAX = 3;
endpackage

// File: rtl/mem_port_arbiter.sv
// Single-ported RAM arbiter between instruction fetch and load/store: one transaction
// in flight, MEM priority with a starvation guard for IF, combinational grants and stalls.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
    parameter int MEM_PRIO_MAX = DEF_MEM_PRIO_MAX
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_done,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [DATA_W/8-1:0] mem_be,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_gnt,
    output logic                mem_done,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_stall,
    output logic                ram_en,
    output logic                ram_we,
    output logic [DATA_W/8-1:0] ram_be,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);
    arb_state_t  state_q, state_d;
    logic [2:0]  lat_q, lat_d;
    logic [7:0]  starve_q, starve_d;
    logic        rst_q;
    logic        blank, busy, cmpl, window, starved;
    arb_owner_t  win;

    always_comb begin
        // Outputs are forced quiet during reset and the cycle right after it.
        blank   = reset | rst_q;
        busy    = (state_q != IDLE);
        cmpl    = busy && (lat_q == 3'(MEM_LATENCY - 1));
        window  = !blank && (!busy || cmpl);
        starved = (starve_q == 8'(MEM_PRIO_MAX));

        if_gnt  = window && if_req && (!mem_req || starved);
        mem_gnt = window && mem_req && !if_gnt;
        win     = if_gnt ? OWN_IF : OWN_MEM;

        if_done   = !blank && cmpl && (state_q == BUSY_IF);
        mem_done  = !blank && cmpl && (state_q == BUSY_MEM);
        if_rdata  = if_done  ? ram_rdata : '0;
        mem_rdata = mem_done ? ram_rdata : '0;
        if_stall  = !blank && ((if_req && !if_gnt) || (state_q == BUSY_IF && !if_done));
        mem_stall = !blank && ((mem_req && !mem_gnt) || (state_q == BUSY_MEM && !mem_done));

        ram_en    = if_gnt | mem_gnt;
        ram_we    = 1'b0;
        ram_be    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (ram_en) begin
            if (win == OWN_IF) begin
                ram_addr = if_addr;
                ram_be   = '1;
            end else begin
                ram_we    = mem_we;
                ram_be    = mem_be;
                ram_addr  = mem_addr;
                ram_wdata = mem_wdata;
            end
        end

        state_d  = state_q;
        lat_d    = lat_q + 3'd1;
        starve_d = starve_q;
        if (if_gnt) begin
            state_d  = BUSY_IF;
            lat_d    = '0;
            starve_d = '0;
        end else if (mem_gnt) begin
            state_d  = BUSY_MEM;
            lat_d    = '0;
            // Only MEM wins taken while IF is waiting count toward starvation.
            if (!if_req)      starve_d = '0;
            else if (!starved) starve_d = starve_q + 8'd1;
        end else if (!busy || cmpl) begin
            state_d = IDLE;
            lat_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        rst_q <= reset;
        if (reset) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a latency-2 arbiter driven through directed scenarios, plus a
// latency-1 instance for back-to-back fetch throughput.
module tb_mem_port_arbiter;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        if_req, if_gnt, if_done, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_done, mem_stall;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        ram_en, ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    logic        b_if_req, b_if_gnt, b_if_done, b_if_stall;
    logic [31:0] b_if_addr, b_if_rdata;
    logic        b_mem_req, b_mem_we, b_mem_gnt, b_mem_done, b_mem_stall;
    logic [3:0]  b_mem_be;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_ram_en, b_ram_we;
    logic [3:0]  b_ram_be;
    logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L), .MEM_PRIO_MAX(3)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_done(mem_done),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .MEM_PRIO_MAX(3)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_done(b_if_done),
        .if_rdata(b_if_rdata), .if_stall(b_if_stall),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_gnt(b_mem_gnt), .mem_done(b_mem_done),
        .mem_rdata(b_mem_rdata), .mem_stall(b_mem_stall),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_be(b_ram_be), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata));

    int errs = 0, checks = 0, cycn = 0, stall_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return (a == 32'h100) ? 32'h00500093 : {a[15:0], ~a[15:0]};
    endfunction

    // RAM models: read data appears L (resp. 1) cycles after the ram_en cycle.
    logic [31:0] r0, r1, b_r0;
    always @(posedge clk) begin
        r0   <= ram_en   ? ram_word(ram_addr)   : 32'hBAD0BAD0;
        r1   <= r0;
        b_r0 <= b_ram_en ? ram_word(b_ram_addr) : 32'hBAD0BAD0;
        cycn <= cycn + 1;
    end
    assign ram_rdata   = r1;
    assign b_ram_rdata = b_r0;

    logic any_out;
    assign any_out = |{if_gnt, if_done, if_rdata, if_stall, mem_gnt, mem_done, mem_rdata,
                       mem_stall, ram_en, ram_we, ram_be, ram_addr, ram_wdata,
                       b_if_gnt, b_if_done, b_if_rdata, b_if_stall, b_mem_gnt, b_mem_done,
                       b_mem_rdata, b_mem_stall, b_ram_en, b_ram_we, b_ram_be, b_ram_addr,
                       b_ram_wdata};

    typedef struct {bit own; bit st; logic [31:0] data; int cyc;} exp_t;
    exp_t sb[$];
    exp_t e, p;

    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (if_done || mem_done) begin
                if (sb.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("done_owner", mem_done, e.own);
                    chk("done_cycle", cycn, e.cyc + L);
                    if (!e.st) chk("done_rdata", mem_done ? mem_rdata : if_rdata, e.data);
                end
            end
            if (if_gnt || mem_gnt) begin
                chk("gnt_excl", if_gnt & mem_gnt, 0);
                chk("gnt_ram_addr", ram_addr, mem_gnt ? mem_addr : if_addr);
                p.own  = mem_gnt;
                p.st   = mem_gnt & mem_we;
                p.data = ram_word(mem_gnt ? mem_addr : if_addr);
                p.cyc  = cycn;
                sb.push_back(p);
            end
        end
    end

    bit gs[16];
    int gc[16];
    bit exp_cont[8]   = '{0, 0, 0, 1, 0, 0, 0, 1};
    bit exp_starve[7] = '{0, 0, 0, 0, 0, 0, 1};

    // Records the owner (1 = IF) and cycle of the next n grants on the L=2 instance.
    task automatic run_grants(input int n, input bit starve_test);
        int gn = 0;
        int t = 0;
        while (gn < n && t < 100) begin
            @(negedge clk);
            t++;
            if (gn < 3 || (gn == 3 && !if_gnt)) stall_cnt += int'(if_stall);
            if (if_gnt || mem_gnt) begin
                gs[gn] = if_gnt;
                gc[gn] = cycn;
                gn++;
            end
            @(posedge clk);
            #1;
            if (starve_test) if_req = (gn != 2);
        end
        chk("grant_count", gn, n);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 0; mem_we = 0; mem_be = 0; mem_addr = 0; mem_wdata = 0;
        b_if_req = 0; b_if_addr = 0;
        b_mem_req = 0; b_mem_we = 0; b_mem_be = 0; b_mem_addr = 0; b_mem_wdata = 0;

        @(negedge clk); chk("rst_zero", any_out, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); chk("rst_after_zero", any_out, 0);

        // Lone fetch
        @(negedge clk);
        chk("fetch_gnt", if_gnt, 1);
        chk("fetch_ram_en", ram_en, 1);
        chk("fetch_we_be", {ram_we, ram_be}, 5'b01111);
        chk("fetch_stall_gnt", if_stall, 0);
        @(posedge clk); #1 if_req = 0;
        @(negedge clk);
        chk("fetch_stall_busy", if_stall, 1);
        chk("fetch_done_early", if_done, 0);
        chk("idle_ram_en", ram_en, 0);
        @(negedge clk);
        chk("fetch_done", if_done, 1);
        chk("fetch_rdata", if_rdata, 32'h00500093);
        chk("fetch_stall_done", if_stall, 0);

        // Contention
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h300; mem_req = 1; mem_we = 0; mem_addr = 32'h2000;
        stall_cnt = 0;
        run_grants(8, 0);
        if_req = 0; mem_req = 0;
        for (int i = 0; i < 8; i++) chk("cont_seq", gs[i], exp_cont[i]);
        for (int i = 1; i < 8; i++) chk("cont_gap", gc[i] - gc[i-1], L);
        chk("cont_if_stall", stall_cnt, 6);
        drain();

        // Store
        mem_req = 1; mem_we = 1; mem_be = 4'b0011; mem_addr = 32'h2004; mem_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("st_gnt", mem_gnt, 1);
        chk("st_we_be", {ram_we, ram_be}, 5'b10011);
        chk("st_wdata", ram_wdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        mem_req = 0; mem_we = 0; mem_be = 0; mem_wdata = 0;
        @(negedge clk);
        chk("st_after_ctl", {ram_en, ram_we, ram_be}, 0);
        chk("st_after_wdata", ram_wdata, 0);
        chk("st_stall_busy", mem_stall, 1);
        drain();

        // Starve counter clear
        if_req = 1; if_addr = 32'h500; mem_req = 1; mem_we = 0; mem_addr = 32'h2008;
        run_grants(7, 1);
        if_req = 0; mem_req = 0;
        for (int i = 0; i < 7; i++) chk("starve_seq", gs[i], exp_starve[i]);
        drain();

        // Reset in flight
        mem_req = 1; mem_addr = 32'h2100;
        @(negedge clk); chk("rm_gnt", mem_gnt, 1);
        @(posedge clk); #1 mem_req = 0; reset = 1;
        @(negedge clk); chk("rm_zero", any_out, 0);
        @(posedge clk); #1 reset = 0;
        @(negedge clk); chk("rm_zero_after", any_out, 0);
        @(negedge clk); chk("rm_no_done", mem_done, 0);
        @(posedge clk); #1 if_req = 1; if_addr = 32'h104;
        @(negedge clk); chk("rm_new_gnt", if_gnt, 1);
        @(posedge clk); #1 if_req = 0;
        drain();

        // Latency-1 back-to-back fetches
        b_if_req = 1; b_if_addr = 32'h400;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("l1_gnt", b_if_gnt, 1);
            chk("l1_ram_en", b_ram_en, 1);
            chk("l1_stall", b_if_stall, 0);
            if (k > 0) begin
                chk("l1_done", b_if_done, 1);
                chk("l1_rdata", b_if_rdata, ram_word(32'h400 + 32'(4 * (k - 1))));
            end else begin
                chk("l1_done_first", b_if_done, 0);
            end
            @(posedge clk); #1;
            if (k < 3) b_if_addr = b_if_addr + 32'd4;
            else b_if_req = 0;
        end
        @(negedge clk);
        chk("l1_done_last", b_if_done, 1);
        chk("l1_rdata_last", b_if_rdata, ram_word(32'h40C));
        chk("l1_idle_en", b_ram_en, 0);
        chk("l1_idle_stall", b_if_stall, 0);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
